// File: rtl/spi_pkg.sv
// Shared types and defaults for the framed SPI receiver.
`timescale 1ns/1ps
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

    localparam int SPI_SYNC_DEFAULT = 2;

    // Leading edge is rising for mode 0, trailing edge is rising for mode 3.
    function automatic logic sample_on_rise(input spi_mode_t mode);
        return (mode.cpol == mode.cpha);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage flip-flop synchroniser with a configurable reset level.
`timescale 1ns/1ps
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES    = SPI_SYNC_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the stage chain.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_r[STAGES-1];

endmodule

// File: rtl/spi_rx_framed.sv
// SPI slave receiver: oversampled bus, all four modes, CS-framed words,
// valid/ready output with sticky overrun and abort pulse.
`timescale 1ns/1ps
module spi_rx_framed
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             rx_en_i,
    input  logic [1:0]       mode_i,
    input  logic             SCLK_i,
    input  logic             MISO_i,
    input  logic             CS_n_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             overrun_o,
    input  logic             overrun_clr_i,
    output logic             abort_o
);

    localparam int                 CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WIDTH - 1);

    logic sclk_s, miso_s, cs_n_s;
    logic sclk_d_r, cs_n_d_r;
    logic [FLUSH_W-1:0] flush_r;
    logic rise_r, fall_r, cs_fall_r, cs_rise_r;

    rx_state_t        state_r;
    spi_mode_t        mode_r;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [WIDTH-1:0] shift_r, shift_next_s, word_r;
    logic             done_r, abort_r, sample_s, word_done_s;

    logic [WIDTH-1:0] data_r;
    logic             valid_r, overrun_r, overrun_set_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock_i(clock_i), .reset_i(reset_i), .d_i(SCLK_i), .q_o(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_miso (
        .clock_i(clock_i), .reset_i(reset_i), .d_i(MISO_i), .q_o(miso_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clock_i(clock_i), .reset_i(reset_i), .d_i(CS_n_i), .q_o(cs_n_s));

    // Register bus edges; edges are suppressed until the synchronisers have
    // flushed their reset levels, so a CS_n held low across reset never re-arms.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sclk_d_r  <= 1'b0;
            cs_n_d_r  <= 1'b1;
            flush_r   <= FLUSH_INIT;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            cs_fall_r <= 1'b0;
            cs_rise_r <= 1'b0;
        end else begin
            sclk_d_r <= sclk_s;
            cs_n_d_r <= cs_n_s;
            if (flush_r != '0) begin
                flush_r   <= flush_r - FLUSH_W'(1);
                rise_r    <= 1'b0;
                fall_r    <= 1'b0;
                cs_fall_r <= 1'b0;
                cs_rise_r <= 1'b0;
            end else begin
                rise_r    <= sclk_s & ~sclk_d_r;
                fall_r    <= ~sclk_s & sclk_d_r;
                cs_fall_r <= ~cs_n_s & cs_n_d_r;
                cs_rise_r <= cs_n_s & ~cs_n_d_r;
            end
        end
    end

    // Next shift/counter values for a sample edge in the active frame.
    always_comb begin
        sample_s     = (state_r == ACTIVE) &&
                       (sample_on_rise(mode_r) ? rise_r : fall_r);
        shift_next_s = shift_r;
        cnt_next_s   = cnt_r;
        word_done_s  = 1'b0;
        if (sample_s) begin
            if (MSB_FIRST) begin
                shift_next_s = {shift_r[WIDTH-2:0], miso_s};
            end else begin
                shift_next_s = {miso_s, shift_r[WIDTH-1:1]};
            end
            if (cnt_r == CNT_LAST) begin
                cnt_next_s  = '0;
                word_done_s = 1'b1;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            shift_next_s = shift_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Frame FSM: the sample is applied before CS_n rising is evaluated.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            mode_r  <= '0;
            cnt_r   <= '0;
            shift_r <= '0;
            word_r  <= '0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            abort_r <= 1'b0;
            if (!rx_en_i) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (cs_fall_r) begin
                            state_r <= ACTIVE;
                            mode_r  <= spi_mode_t'(mode_i);
                            cnt_r   <= '0;
                            shift_r <= '0;
                        end
                    end
                    ACTIVE: begin
                        shift_r <= shift_next_s;
                        cnt_r   <= cnt_next_s;
                        if (word_done_s) begin
                            word_r <= shift_next_s;
                            done_r <= 1'b1;
                        end
                        if (cs_rise_r) begin
                            state_r <= IDLE;
                            abort_r <= (cnt_next_s != '0);
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign overrun_set_s = done_r && valid_r && !rx_ready_i;

    // Output register with valid/ready handshake; overrun set beats clear.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (done_r && (!valid_r || rx_ready_i)) begin
                data_r  <= word_r;
                valid_r <= 1'b1;
            end else if (valid_r && rx_ready_i) begin
                valid_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rx_data_o  = data_r;
    assign rx_valid_o = valid_r;
    assign overrun_o  = overrun_r;
    assign abort_o    = abort_r;

endmodule

// File: tb/tb_spi_rx_framed.sv
// Directed bench for spi_rx_framed: vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_spi_rx_framed;

    localparam int H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rx_en_a, rx_en_b, sclk, miso, cs_n, ready, ready_b, clr;
    logic [1:0] mode;
    logic [7:0] data_a;
    logic       valid_a, ovr_a, abort_a;
    logic [11:0] data_b;
    logic       valid_b, ovr_b, abort_b;

    int total = 0;
    int bad = 0;
    int abort_cycles = 0;
    int abort_b_cycles = 0;
    logic [7:0]  got_q[$];
    logic [11:0] got_b_q[$];

    spi_rx_framed #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
        .clock_i(clk), .reset_i(reset), .rx_en_i(rx_en_a), .mode_i(mode),
        .SCLK_i(sclk), .MISO_i(miso), .CS_n_i(cs_n),
        .rx_data_o(data_a), .rx_valid_o(valid_a), .rx_ready_i(ready),
        .overrun_o(ovr_a), .overrun_clr_i(clr), .abort_o(abort_a));

    spi_rx_framed #(.WIDTH(12), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
        .clock_i(clk), .reset_i(reset), .rx_en_i(rx_en_b), .mode_i(mode),
        .SCLK_i(sclk), .MISO_i(miso), .CS_n_i(cs_n),
        .rx_data_o(data_b), .rx_valid_o(valid_b), .rx_ready_i(ready_b),
        .overrun_o(ovr_b), .overrun_clr_i(clr), .abort_o(abort_b));

    // Record every accepted word and every abort cycle.
    always @(negedge clk) begin
        if (valid_a && ready) got_q.push_back(data_a);
        if (abort_a) abort_cycles++;
        if (valid_b && ready_b) got_b_q.push_back(data_b);
        if (abort_b) abort_b_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [1:0] m, input logic b);
        if (m[0] == 1'b0) begin
            miso = b;
            tick(H);
            sclk = ~m[1];
            tick(H);
            sclk = m[1];
        end else begin
            sclk = ~m[1];
            miso = b;
            tick(H);
            sclk = m[1];
            tick(H);
        end
    endtask

    task automatic send_word(input logic [1:0] m, input logic [31:0] d, input int n, input bit lsb);
        for (int i = 0; i < n; i++) send_bit(m, lsb ? d[i] : d[n-1-i]);
    endtask

    task automatic cs_low(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        tick(H);
        cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_high();
        tick(H);
        cs_n = 1'b1;
        tick(H);
    endtask

    task automatic frame(input logic [1:0] m, input logic [31:0] d, input int n, input bit lsb);
        cs_low(m);
        send_word(m, d, n, lsb);
        cs_high();
    endtask

    // Compare the idx-th accepted word if it exists, else flag the missing count.
    task automatic expect_word(input string name, input int idx, input logic [7:0] exp);
        if (idx < got_q.size()) check(name, 32'(got_q[idx]), 32'(exp));
        else check({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int idx, ab0, lat;
        logic [7:0] v;

        vecs[0] = '{mode: 2'd0, tx: 8'h3C, exp: 8'h3C};
        vecs[1] = '{mode: 2'd1, tx: 8'hC3, exp: 8'hC3};
        vecs[2] = '{mode: 2'd2, tx: 8'h81, exp: 8'h81};
        vecs[3] = '{mode: 2'd3, tx: 8'h7E, exp: 8'h7E};
        vecs[4] = '{mode: 2'd0, tx: 8'h00, exp: 8'h00};
        vecs[5] = '{mode: 2'd3, tx: 8'hFF, exp: 8'hFF};

        reset = 1'b1; rx_en_a = 1'b1; rx_en_b = 1'b0; sclk = 1'b0; miso = 1'b0;
        cs_n = 1'b1; ready = 1'b1; ready_b = 1'b1; clr = 1'b0; mode = 2'd0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_data", 32'(data_a), 32'h0);
        check("reset_valid", 32'(valid_a), 32'h0);
        check("reset_overrun", 32'(ovr_a), 32'h0);
        check("reset_abort", 32'(abort_a), 32'h0);

        // Test 1: mode 0 0xA5 with latency measured from the final sample edge.
        idx = got_q.size(); ab0 = abort_cycles; v = 8'hA5;
        cs_low(2'd0);
        for (int i = 0; i < 7; i++) send_bit(2'd0, v[7-i]);
        miso = v[0];
        tick(H);
        sclk = 1'b1;
        lat = 0;
        while (!valid_a && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("t1_latency_edges", 32'(lat), 32'd5);
        tick(H);
        sclk = 1'b0;
        cs_high();
        check("t1_count", 32'(got_q.size()), 32'(idx + 1));
        expect_word("t1_data", idx, 8'hA5);
        check("t1_abort", 32'(abort_cycles - ab0), 32'd0);
        check("t1_overrun", 32'(ovr_a), 32'h0);

        // Single-word frames over all modes.
        for (int k = 0; k < 6; k++) begin
            idx = got_q.size();
            frame(vecs[k].mode, 32'(vecs[k].tx), 8, 1'b0);
            check($sformatf("vec%0d_count", k), 32'(got_q.size()), 32'(idx + 1));
            expect_word($sformatf("vec%0d_data", k), idx, vecs[k].exp);
        end

        // Test 2: three words per frame in mode 3 then mode 1.
        for (int m = 0; m < 2; m++) begin
            logic [1:0] md;
            md = (m == 0) ? 2'd3 : 2'd1;
            idx = got_q.size(); ab0 = abort_cycles;
            cs_low(md);
            send_word(md, 32'hAA, 8, 1'b0);
            send_word(md, 32'hBB, 8, 1'b0);
            send_word(md, 32'hCC, 8, 1'b0);
            cs_high();
            check($sformatf("t2_m%0d_count", md), 32'(got_q.size()), 32'(idx + 3));
            expect_word($sformatf("t2_m%0d_w0", md), idx, 8'hAA);
            expect_word($sformatf("t2_m%0d_w1", md), idx + 1, 8'hBB);
            expect_word($sformatf("t2_m%0d_w2", md), idx + 2, 8'hCC);
            check($sformatf("t2_m%0d_abort", md), 32'(abort_cycles - ab0), 32'd0);
        end

        // Test 3: 12-bit LSB-first instance, mode 2.
        rx_en_a = 1'b0; rx_en_b = 1'b1;
        idx = got_b_q.size();
        frame(2'd2, 32'h5C3, 12, 1'b1);
        check("t3_count", 32'(got_b_q.size()), 32'(idx + 1));
        if (idx < got_b_q.size()) check("t3_data", 32'(got_b_q[idx]), 32'h5C3);
        check("t3_abort", 32'(abort_b_cycles), 32'd0);
        rx_en_a = 1'b1; rx_en_b = 1'b0;

        // Test 4: overrun while output is full, clear, then accept.
        ready = 1'b0;
        idx = got_q.size();
        frame(2'd0, 32'h11, 8, 1'b0);
        check("t4_valid1", 32'(valid_a), 32'h1);
        check("t4_data1", 32'(data_a), 32'h11);
        check("t4_ovr1", 32'(ovr_a), 32'h0);
        frame(2'd0, 32'h22, 8, 1'b0);
        check("t4_valid2", 32'(valid_a), 32'h1);
        check("t4_data2", 32'(data_a), 32'h11);
        check("t4_ovr2", 32'(ovr_a), 32'h1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t4_ovr_clr", 32'(ovr_a), 32'h0);
        ready = 1'b1;
        tick(1);
        check("t4_valid_after", 32'(valid_a), 32'h0);
        check("t4_count", 32'(got_q.size()), 32'(idx + 1));
        expect_word("t4_accepted", idx, 8'h11);

        // Test 5: partial word aborted, then a full byte.
        idx = got_q.size(); ab0 = abort_cycles;
        cs_low(2'd0);
        send_word(2'd0, 32'h16, 5, 1'b0);
        cs_high();
        check("t5_abort_cycles", 32'(abort_cycles - ab0), 32'd1);
        check("t5_valid", 32'(valid_a), 32'h0);
        check("t5_no_word", 32'(got_q.size()), 32'(idx));
        frame(2'd0, 32'h3C, 8, 1'b0);
        check("t5_count", 32'(got_q.size()), 32'(idx + 1));
        expect_word("t5_data", idx, 8'h3C);
        check("t5_abort_after", 32'(abort_cycles - ab0), 32'd1);

        // Test 6: reset mid-frame clears outputs and disarms the bus.
        ready = 1'b0;
        cs_low(2'd0);
        send_word(2'd0, 32'h99, 8, 1'b0);
        send_word(2'd0, 32'h66, 8, 1'b0);
        cs_high();
        check("t6_pre_valid", 32'(valid_a), 32'h1);
        check("t6_pre_ovr", 32'(ovr_a), 32'h1);
        check("t6_pre_data", 32'(data_a), 32'h99);
        ab0 = abort_cycles;
        cs_low(2'd0);
        send_word(2'd0, 32'h5, 3, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_data", 32'(data_a), 32'h0);
        check("t6_rst_valid", 32'(valid_a), 32'h0);
        check("t6_rst_ovr", 32'(ovr_a), 32'h0);
        check("t6_rst_abort", 32'(abort_a), 32'h0);
        ready = 1'b1;
        idx = got_q.size();
        send_word(2'd0, 32'h1F, 5, 1'b0);
        send_word(2'd0, 32'hE7, 8, 1'b0);
        cs_high();
        check("t6_no_word", 32'(got_q.size()), 32'(idx));
        check("t6_no_abort", 32'(abort_cycles - ab0), 32'd0);
        frame(2'd0, 32'h7E, 8, 1'b0);
        check("t6_count", 32'(got_q.size()), 32'(idx + 1));
        expect_word("t6_data", idx, 8'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rx_framed.md
Name: spi_rx_framed

Overview:
Parametrised SPI slave-side receiver, the successor to spi_rx. It oversamples external SCLK/MISO/CS_n on the system clock and supports all four SPI modes (CPOL/CPHA). Words are framed by chip-select, with configurable width and bit order. Completed words go to the ADC sample path through a valid/ready handshake, with overrun and abort reporting.

Parameters:
WIDTH, 8, bits per received word (2..32)
MSB_FIRST, 1, 1 = first sampled bit lands in bit WIDTH-1; 0 = first bit lands in bit 0
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (>=2)

Ports:
clock_i  input  1  system clock; all logic on rising edge
reset_i  input  1  synchronous, active-high reset
rx_en_i  input  1  receiver enable; low forces IDLE and ignores the bus
mode_i  input  2  {CPOL,CPHA}; latched at frame start
SCLK_i  input  1  asynchronous SPI clock
MISO_i  input  1  asynchronous serial data
CS_n_i  input  1  asynchronous chip select, active low
rx_data_o  output  WIDTH  received word, held while rx_valid_o=1
rx_valid_o  output  1  word available
rx_ready_i  input  1  consumer accepts the word when rx_valid_o & rx_ready_i
overrun_o  output  1  sticky: a word completed while the output was still full
overrun_clr_i  input  1  clears overrun_o
abort_o  output  1  one-cycle pulse: CS_n deasserted with a partial word

Behaviour:
- Reset: all outputs 0. State=IDLE. Bit counter=0. Shift register=0. Synchroniser flops load their idle levels: SCLK=0, MISO=0, CS_n=1.
- Synchronisers: SCLK_i, MISO_i and CS_n_i each pass through SYNC_STAGES flops. Edge detection compares the last synchronised stage with one extra delay flop.
- Sample edge:
  - CPHA=0: leading edge (rising if CPOL=0, falling if CPOL=1).
  - CPHA=1: trailing edge (the opposite transition).
  - The other edge is ignored. MISO is taken from the same-cycle synchronised stage.
- State machine:
  - IDLE -> ACTIVE when rx_en_i=1 and a synchronised CS_n falling edge occurs. mode_i is latched, the counter is cleared and the shift register is cleared.
  - ACTIVE: each sample edge shifts in one bit and increments the counter.
    - MSB_FIRST=1: shift left, new bit into bit 0.
    - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
  - When the counter reaches WIDTH-1 and a sample edge occurs, the word is complete. The counter wraps to 0 and the FSM stays in ACTIVE, so multiple words per frame are allowed.
  - ACTIVE -> IDLE on synchronised CS_n rising edge. If the counter is non-zero, abort_o pulses one cycle and the partial word is discarded.
  - Any state -> IDLE, same cycle, when rx_en_i=0. No abort pulse; the output register is untouched.
- Output handshake: a completed word loads rx_data_o and sets rx_valid_o on the next clock.
  - Empty output: the word loads normally.
  - Output full and rx_ready_i=0 at completion: the new word is dropped, rx_data_o keeps the old word, and overrun_o is set.
  - Completion in the same cycle as rx_ready_i=1 with valid: the new word loads, rx_valid_o stays 1, no overrun.
  - rx_valid_o never drops without a handshake, except on reset.
- overrun_o: if overrun_clr_i and a new overrun occur in the same cycle, set wins.
- Latency: rx_valid_o rises SYNC_STAGES+2 clock_i cycles after the clock edge at which the final sample SCLK_i edge is first registered.
- Bus constraint: the SCLK half-period must be at least SYNC_STAGES+2 clock_i cycles. Faster SCLK is unsupported and its behaviour is undefined.
- Simultaneous sample edge and CS_n rising edge: the sample is taken first, then CS_n is evaluated. A word completing on that edge is delivered with no abort.
- reset_i mid-frame: everything returns to reset values. The bus is re-armed only by a fresh CS_n falling edge.

Decomposition:
- spi_pkg holds:
  - typedef spi_mode_t (packed struct: cpol, cpha)
  - typedef enum rx_state_t {IDLE, ACTIVE}
  - localparam SPI_SYNC_DEFAULT = 2
- Sub-module spi_sync: a parametrised N-stage synchroniser with a reset value parameter. It is instantiated three times.

Test Plan:
1. Mode 0, MSB_FIRST=1, CS low, shift 0xA5, CS high, rx_ready_i=1 -> one rx_valid_o pulse with rx_data_o=0xA5, abort_o=0, overrun_o=0.
2. Mode 3 and mode 1, bytes 0xAA, 0xBB, 0xCC in one CS frame, rx_ready_i=1 -> three words 0xAA, 0xBB, 0xCC in order.
3. Separate instance with MSB_FIRST=0 and WIDTH=12, mode 2, sending LSB-first bits of 0x5C3 -> rx_data_o=0x5C3.
4. rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11 and overrun_o=1. Pulse overrun_clr_i -> overrun_o=0. Assert ready -> 0x11 accepted, rx_valid_o=0.
5. CS_n rises after 5 of 8 bits -> abort_o high for exactly 1 cycle and rx_valid_o stays 0. A following full byte 0x3C is received correctly.
6. reset_i asserted for 1 cycle after bit 3 of 8 -> all outputs 0. Without a new CS_n falling edge, the remaining SCLK toggles produce no word. With a new frame, 0x7E is received.
